// File: rtl/osd_dem_uart_fifo_if.sv
// osd_dem_uart_fifo_if
//   Bundles every stream, control and status signal of osd_dem_uart_fifo.
//   Host TX stream : tx_data, tx_valid, tx_ready, tx_flush
//   Host RX stream : rx_data, rx_valid, rx_ready
//   DEM out stream : out_char, out_valid, out_ready
//   DEM in stream  : in_char, in_valid, in_ready
//   DEM status     : drop
//   Status outputs : tx_level, rx_level, drop_count
//   The slave modport is the FIFO's view. The master modport is the view of
//   whatever drives the host and DEM sides.
interface osd_dem_uart_fifo_if #(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
);
  logic [7:0]                  tx_data;
  logic                        tx_valid;
  logic                        tx_ready;
  logic                        tx_flush;
  logic [7:0]                  rx_data;
  logic                        rx_valid;
  logic                        rx_ready;
  logic [7:0]                  out_char;
  logic                        out_valid;
  logic                        out_ready;
  logic [7:0]                  in_char;
  logic                        in_valid;
  logic                        in_ready;
  logic                        drop;
  logic [$clog2(TX_DEPTH):0]   tx_level;
  logic [$clog2(RX_DEPTH):0]   rx_level;
  logic [15:0]                 drop_count;

  modport slave (
    input  tx_data, tx_valid, tx_flush, rx_ready, out_ready,
    input  in_char, in_valid, drop,
    output tx_ready, rx_data, rx_valid, out_char, out_valid, in_ready,
    output tx_level, rx_level, drop_count
  );

  modport master (
    output tx_data, tx_valid, tx_flush, rx_ready, out_ready,
    output in_char, in_valid, drop,
    input  tx_ready, rx_data, rx_valid, out_char, out_valid, in_ready,
    input  tx_level, rx_level, drop_count
  );
endinterface

// File: rtl/osd_dem_uart_fifo.sv
// osd_dem_uart_fifo
//   Character buffer between the device-side UART and osd_dem_uart. A TX FIFO
//   carries host bytes towards the DEM, an RX FIFO carries DEM bytes back to
//   the host. While the DEM signals drop, TX head bytes are either discarded
//   (and counted) or held, depending on DISCARD_ON_DROP.
//   Ports:
//     clk   : single clock
//     rst_n : asynchronous active-low reset, clears pointers/levels/counter
//     bus   : osd_dem_uart_fifo_if slave modport (host + DEM streams, status)
module osd_dem_uart_fifo #(
  parameter int TX_DEPTH        = 16,
  parameter int RX_DEPTH        = 16,
  parameter bit DISCARD_ON_DROP = 1'b1
) (
  input logic                clk,
  input logic                rst_n,
  osd_dem_uart_fifo_if.slave bus
);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int TX_LW = TX_AW + 1;
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int RX_LW = RX_AW + 1;

  logic [7:0]       txMem [TX_DEPTH];
  logic [TX_AW-1:0] txWrPtr_q, txWrPtr_d;
  logic [TX_AW-1:0] txRdPtr_q, txRdPtr_d;
  logic [TX_LW-1:0] txLevel_q, txLevel_d;
  logic [15:0]      dropCount_q, dropCount_d;
  logic             txEmpty, txFull, txPush, txPop, txDiscard, txAdvance;

  logic [7:0]       rxMem [RX_DEPTH];
  logic [RX_AW-1:0] rxWrPtr_q, rxWrPtr_d;
  logic [RX_AW-1:0] rxRdPtr_q, rxRdPtr_d;
  logic [RX_LW-1:0] rxLevel_q, rxLevel_d;
  logic             rxEmpty, rxFull, rxPush, rxPop;

  // TX next state. Full is judged from the registered level only, so a push
  // at full is refused even when the head leaves in the same cycle. A flush
  // snaps the read pointer onto the write pointer and swallows any push; a
  // discard happening in the flush cycle is not counted since the flush
  // empties the FIFO anyway.
  always_comb begin
    txEmpty     = (txLevel_q == '0);
    txFull      = (txLevel_q == TX_LW'(TX_DEPTH));
    txPush      = bus.tx_valid & ~txFull & ~bus.tx_flush;
    txPop       = ~txEmpty & ~bus.drop & bus.out_ready;
    txDiscard   = DISCARD_ON_DROP & bus.drop & ~txEmpty;
    txAdvance   = txPop | txDiscard;
    txWrPtr_d   = txWrPtr_q;
    txRdPtr_d   = txRdPtr_q;
    txLevel_d   = txLevel_q;
    dropCount_d = dropCount_q;
    if (bus.tx_flush) begin
      txRdPtr_d = txWrPtr_q;
      txLevel_d = '0;
    end else begin
      if (txPush) txWrPtr_d = txWrPtr_q + TX_AW'(1);
      if (txAdvance) txRdPtr_d = txRdPtr_q + TX_AW'(1);
      txLevel_d = txLevel_q + TX_LW'(txPush) - TX_LW'(txAdvance);
      if (txDiscard && (dropCount_q != 16'hFFFF)) dropCount_d = dropCount_q + 16'd1;
    end
  end

  // RX next state; same full/empty rule as TX, no flush and no drop handling.
  always_comb begin
    rxEmpty   = (rxLevel_q == '0);
    rxFull    = (rxLevel_q == RX_LW'(RX_DEPTH));
    rxPush    = bus.in_valid & ~rxFull;
    rxPop     = ~rxEmpty & bus.rx_ready;
    rxWrPtr_d = rxPush ? rxWrPtr_q + RX_AW'(1) : rxWrPtr_q;
    rxRdPtr_d = rxPop ? rxRdPtr_q + RX_AW'(1) : rxRdPtr_q;
    rxLevel_d = rxLevel_q + RX_LW'(rxPush) - RX_LW'(rxPop);
  end

  // Pointer, level and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txWrPtr_q   <= '0;
      txRdPtr_q   <= '0;
      txLevel_q   <= '0;
      dropCount_q <= '0;
      rxWrPtr_q   <= '0;
      rxRdPtr_q   <= '0;
      rxLevel_q   <= '0;
    end else begin
      txWrPtr_q   <= txWrPtr_d;
      txRdPtr_q   <= txRdPtr_d;
      txLevel_q   <= txLevel_d;
      dropCount_q <= dropCount_d;
      rxWrPtr_q   <= rxWrPtr_d;
      rxRdPtr_q   <= rxRdPtr_d;
      rxLevel_q   <= rxLevel_d;
    end
  end

  // Storage arrays carry no reset; stale contents are unreachable once the
  // levels are cleared.
  always_ff @(posedge clk) begin
    if (txPush) txMem[txWrPtr_q] <= bus.tx_data;
    if (rxPush) rxMem[rxWrPtr_q] <= bus.in_char;
  end

  assign bus.tx_ready   = ~txFull;
  assign bus.out_valid  = ~txEmpty & ~bus.drop;
  assign bus.out_char   = txMem[txRdPtr_q];
  assign bus.tx_level   = txLevel_q;
  assign bus.drop_count = dropCount_q;
  assign bus.in_ready   = ~rxFull;
  assign bus.rx_valid   = ~rxEmpty;
  assign bus.rx_data    = rxMem[rxRdPtr_q];
  assign bus.rx_level   = rxLevel_q;
endmodule

// File: tb/tb_osd_dem_uart_fifo.sv
// tb_osd_dem_uart_fifo
//   Drives the main instance (DISCARD_ON_DROP=1) from directed and random
//   stimulus and compares every cycle against a queue-based reference model.
//   A second instance (DISCARD_ON_DROP=0) exercises the hold-on-drop policy.
module tb_osd_dem_uart_fifo;
  localparam int TXD = 16;
  localparam int RXD = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Free-running clock.
  always #5 clk = ~clk;

  osd_dem_uart_fifo_if #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) hostBus ();
  osd_dem_uart_fifo_if #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) holdBus ();

  osd_dem_uart_fifo #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .DISCARD_ON_DROP(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(hostBus)
  );
  osd_dem_uart_fifo #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .DISCARD_ON_DROP(1'b0)) dutHold (
    .clk(clk), .rst_n(rst_n), .bus(holdBus)
  );

  // Reference model state and bookkeeping.
  logic [7:0]  txQ[$];
  logic [7:0]  rxQ[$];
  logic [7:0]  outLog[$];
  logic [7:0]  txSent[$];
  int unsigned modelDrop = 0;
  bit          lastTxPush, lastRxPush;
  int          testsRun = 0;
  int          testsFailed = 0;

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One clock cycle: check DUT outputs against the model mid-cycle, advance
  // the model with the inputs applied this cycle, return just after the edge.
  task automatic runCycle();
    bit expOutValid, pushT, popT, disc, pushR, popR;
    @(negedge clk);
    expOutValid = (txQ.size() != 0) && !hostBus.drop;
    checkOutput("tx_ready",   hostBus.tx_ready,   32'(txQ.size() != TXD));
    checkOutput("out_valid",  hostBus.out_valid,  32'(expOutValid));
    if (expOutValid) checkOutput("out_char", hostBus.out_char, txQ[0]);
    checkOutput("tx_level",   hostBus.tx_level,   txQ.size());
    checkOutput("drop_count", hostBus.drop_count, modelDrop);
    checkOutput("in_ready",   hostBus.in_ready,   32'(rxQ.size() != RXD));
    checkOutput("rx_valid",   hostBus.rx_valid,   32'(rxQ.size() != 0));
    if (rxQ.size() != 0) checkOutput("rx_data", hostBus.rx_data, rxQ[0]);
    checkOutput("rx_level",   hostBus.rx_level,   rxQ.size());
    if (hostBus.out_valid && hostBus.out_ready) outLog.push_back(hostBus.out_char);

    lastTxPush = hostBus.tx_valid && (txQ.size() < TXD);
    pushT = lastTxPush && !hostBus.tx_flush;
    popT  = expOutValid && hostBus.out_ready;
    disc  = hostBus.drop && (txQ.size() != 0);
    if (hostBus.tx_flush) txQ.delete();
    else begin
      if (popT || disc) void'(txQ.pop_front());
      if (disc && modelDrop < 32'hFFFF) modelDrop++;
      if (pushT) begin
        txQ.push_back(hostBus.tx_data);
        txSent.push_back(hostBus.tx_data);
      end
    end
    pushR = hostBus.in_valid && (rxQ.size() < RXD);
    popR  = (rxQ.size() != 0) && hostBus.rx_ready;
    lastRxPush = pushR;
    if (popR) void'(rxQ.pop_front());
    if (pushR) rxQ.push_back(hostBus.in_char);
    @(posedge clk);
    #1;
  endtask

  // Run cycles with no new TX input until the model TX queue empties.
  task automatic drainTx(input int budget);
    hostBus.tx_valid = 1'b0;
    hostBus.out_ready = 1'b1;
    hostBus.drop = 1'b0;
    for (int c = 0; c < budget && txQ.size() != 0; c++) runCycle();
    checkOutput("tx_drained", hostBus.tx_level, 0);
  endtask

  // Bounded watchdog.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int idx;
    int rxIdx;
    {hostBus.tx_data, hostBus.tx_valid, hostBus.tx_flush, hostBus.rx_ready} = '0;
    {hostBus.out_ready, hostBus.in_char, hostBus.in_valid, hostBus.drop} = '0;
    {holdBus.tx_data, holdBus.tx_valid, holdBus.tx_flush, holdBus.rx_ready} = '0;
    {holdBus.out_ready, holdBus.in_char, holdBus.in_valid, holdBus.drop} = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_tx_ready",  hostBus.tx_ready, 1);
    checkOutput("rst_in_ready",  hostBus.in_ready, 1);
    checkOutput("rst_out_valid", hostBus.out_valid, 0);
    checkOutput("rst_rx_valid",  hostBus.rx_valid, 0);
    checkOutput("rst_drop_cnt",  hostBus.drop_count, 0);
    rst_n = 1'b1;
    runCycle();

    // Three bytes straight through.
    hostBus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      hostBus.tx_valid = 1'b1;
      hostBus.tx_data  = 8'(8'h41 + i);
      runCycle();
    end
    drainTx(10);

    // Fill to full with 17 offered bytes while the DEM stalls.
    hostBus.out_ready = 1'b0;
    txSent.delete();
    outLog.delete();
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      hostBus.tx_valid = (idx < 17);
      hostBus.tx_data  = 8'(8'h60 + idx);
      runCycle();
      if (lastTxPush) idx++;
    end
    checkOutput("full_level", hostBus.tx_level, 16);
    checkOutput("full_ready", hostBus.tx_ready, 0);
    hostBus.out_ready = 1'b1;
    for (int c = 0; c < 60 && (idx < 17 || txQ.size() != 0); c++) begin
      hostBus.tx_valid = (idx < 17);
      hostBus.tx_data  = 8'(8'h60 + idx);
      runCycle();
      if (lastTxPush) idx++;
    end
    checkOutput("full_out_count", outLog.size(), 17);
    for (int i = 0; i < 17; i++) checkOutput("full_out_order", outLog[i], 8'(8'h60 + i));

    // Drop policy on both instances: 5 bytes loaded, drop held 3 cycles.
    hostBus.out_ready = 1'b0;
    holdBus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      hostBus.tx_valid = 1'b1; hostBus.tx_data = 8'(8'h80 + i);
      holdBus.tx_valid = 1'b1; holdBus.tx_data = 8'(8'h80 + i);
      runCycle();
    end
    hostBus.tx_valid = 1'b0; holdBus.tx_valid = 1'b0;
    hostBus.drop = 1'b1; holdBus.drop = 1'b1;
    hostBus.out_ready = 1'b1; holdBus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput("hold_out_valid", holdBus.out_valid, 0);
      runCycle();
    end
    checkOutput("drop_level", hostBus.tx_level, 2);
    checkOutput("drop_count3", hostBus.drop_count, 3);
    checkOutput("hold_level", holdBus.tx_level, 5);
    checkOutput("hold_count", holdBus.drop_count, 0);
    hostBus.drop = 1'b0; holdBus.drop = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checkOutput("hold_out_valid_rel", holdBus.out_valid, 1);
      checkOutput("hold_out_char", holdBus.out_char, 8'(8'h80 + k));
      runCycle();
    end
    checkOutput("hold_drained", holdBus.tx_level, 0);
    holdBus.out_ready = 1'b0;
    drainTx(10);

    // RX fill with the host stalled, then drain while feeding more.
    hostBus.rx_ready = 1'b0;
    rxIdx = 0;
    for (int c = 0; c < 17; c++) begin
      hostBus.in_valid = 1'b1;
      hostBus.in_char  = 8'(8'h10 + rxIdx);
      runCycle();
      if (lastRxPush) rxIdx++;
    end
    checkOutput("rx_full_level", hostBus.rx_level, 16);
    checkOutput("rx_full_ready", hostBus.in_ready, 0);
    hostBus.rx_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      hostBus.in_char = 8'(8'h10 + rxIdx);
      runCycle();
      if (lastRxPush) rxIdx++;
    end
    hostBus.in_valid = 1'b0;
    for (int c = 0; c < 30 && rxQ.size() != 0; c++) runCycle();
    checkOutput("rx_drained", hostBus.rx_level, 0);

    // Pointer wrap: 40 bytes with random DEM backpressure and random RX.
    txSent.delete();
    outLog.delete();
    idx = 0;
    for (int c = 0; c < 400 && idx < 40; c++) begin
      hostBus.tx_valid  = 1'b1;
      hostBus.tx_data   = 8'($urandom);
      hostBus.out_ready = 1'($urandom_range(0, 1));
      hostBus.in_valid  = 1'($urandom_range(0, 1));
      hostBus.in_char   = 8'($urandom);
      hostBus.rx_ready  = 1'($urandom_range(0, 1));
      runCycle();
      if (lastTxPush) idx++;
    end
    hostBus.in_valid = 1'b0;
    drainTx(40);
    checkOutput("wrap_count", outLog.size(), 40);
    for (int i = 0; i < 40; i++) checkOutput("wrap_order", outLog[i], txSent[i]);

    // Asynchronous reset mid-burst with tx_level=7, rx_level=4.
    hostBus.out_ready = 1'b0;
    hostBus.rx_ready  = 1'b0;
    for (int c = 0; c < 30 && rxQ.size() != 0; c++) begin
      hostBus.rx_ready = 1'b1;
      runCycle();
    end
    hostBus.rx_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      hostBus.tx_valid = 1'b1; hostBus.tx_data = 8'(8'hA0 + c);
      hostBus.in_valid = (c < 4); hostBus.in_char = 8'(8'hB0 + c);
      runCycle();
    end
    hostBus.tx_valid = 1'b0; hostBus.in_valid = 1'b0;
    checkOutput("pre_rst_tx_level", hostBus.tx_level, 7);
    checkOutput("pre_rst_rx_level", hostBus.rx_level, 4);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_tx_level",  hostBus.tx_level, 0);
    checkOutput("arst_rx_level",  hostBus.rx_level, 0);
    checkOutput("arst_out_valid", hostBus.out_valid, 0);
    checkOutput("arst_rx_valid",  hostBus.rx_valid, 0);
    checkOutput("arst_drop_cnt",  hostBus.drop_count, 0);
    txQ.delete(); rxQ.delete(); modelDrop = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    runCycle();

    // Flush at tx_level=9 with a simultaneous push.
    for (int c = 0; c < 9; c++) begin
      hostBus.tx_valid = 1'b1; hostBus.tx_data = 8'(8'hC0 + c);
      runCycle();
    end
    checkOutput("pre_flush_level", hostBus.tx_level, 9);
    hostBus.tx_flush = 1'b1; hostBus.tx_data = 8'hEE;
    runCycle();
    hostBus.tx_flush = 1'b0; hostBus.tx_valid = 1'b0;
    checkOutput("flush_level", hostBus.tx_level, 0);
    checkOutput("flush_drop_cnt", hostBus.drop_count, 0);
    runCycle();

    // Random mix of everything, including drop and flush.
    for (int c = 0; c < 300; c++) begin
      hostBus.tx_valid  = 1'($urandom_range(0, 1));
      hostBus.tx_data   = 8'($urandom);
      hostBus.out_ready = 1'($urandom_range(0, 3) != 0);
      hostBus.drop      = ($urandom_range(0, 7) == 0);
      hostBus.tx_flush  = ($urandom_range(0, 31) == 0);
      hostBus.in_valid  = 1'($urandom_range(0, 1));
      hostBus.in_char   = 8'($urandom);
      hostBus.rx_ready  = 1'($urandom_range(0, 1));
      runCycle();
    end
    hostBus.tx_flush = 1'b0;
    hostBus.in_valid = 1'b0;
    hostBus.rx_ready = 1'b1;
    drainTx(40);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
